// File: rtl/merge_output_stage.sv
// merge_output_stage
//   Merges the input arbiter's two data streams into one ordered output
//   stream. The order is set only by merge-control tokens:
//     1 = one d1 packet, 2 = one d2 packet, 3 = one d1 then one d2 packet,
//     0 = illegal (token dropped, bad_ctrl latched).
//   Accepted packets pass through a first-word-fall-through output FIFO.
//
// Ports
//   clk, reset             clock; asynchronous active-high reset
//   d1_data/valid/ready    arbiter data1 stream
//   d2_data/valid/ready    arbiter data2 stream
//   ctrl_data/valid/ready  merge-control token stream
//   out_data/valid/ready   merged stream (FIFO head, zero when empty)
//   fifo_count             current FIFO occupancy
//   pkt_count              packets delivered on out, saturating
//   bad_ctrl               sticky illegal-token flag
module merge_output_stage #(
  parameter int WIDTH      = 11,
  parameter int CTRL_WIDTH = 2,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         d1_data,
  input  logic                     d1_valid,
  output logic                     d1_ready,
  input  logic [WIDTH-1:0]         d2_data,
  input  logic                     d2_valid,
  output logic                     d2_ready,
  input  logic [CTRL_WIDTH-1:0]    ctrl_data,
  input  logic                     ctrl_valid,
  output logic                     ctrl_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_WIDTH-1:0]     pkt_count,
  output logic                     bad_ctrl
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    TAKE1       = 2'd1,
    TAKE2       = 2'd2,
    TAKE1_THEN2 = 2'd3
  } state_t;

  state_t state, stateNext;

  // Holds all ready outputs low until the first edge after reset release.
  logic running;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [PTR_W:0]   count;
  logic [CNT_WIDTH-1:0] pktCnt;
  logic badReg;

  logic full, ctrlFire, d1Fire, d2Fire, push, pop, badSet;
  logic [WIDTH-1:0] pushData;

  // Full is judged on the registered count only, so a pop in the same
  // cycle never frees a slot for a push.
  assign full       = (count == FULL_COUNT);
  assign out_valid  = (count != '0);
  assign out_data   = out_valid ? mem[rdPtr] : '0;
  assign fifo_count = count;
  assign pkt_count  = pktCnt;
  assign bad_ctrl   = badReg;

  assign ctrl_ready = running && (state == IDLE);
  assign d1_ready   = ((state == TAKE1) || (state == TAKE1_THEN2)) && !full;
  assign d2_ready   = (state == TAKE2) && !full;

  assign ctrlFire = ctrl_valid && ctrl_ready;
  assign d1Fire   = d1_valid && d1_ready;
  assign d2Fire   = d2_valid && d2_ready;
  assign push     = d1Fire || d2Fire;
  assign pushData = d1Fire ? d1_data : d2_data;
  assign pop      = out_valid && out_ready;

  always_comb begin
    stateNext = state;
    badSet    = 1'b0;
    case (state)
      IDLE: begin
        if (ctrlFire) begin
          case (ctrl_data)
            CTRL_WIDTH'(1): stateNext = TAKE1;
            CTRL_WIDTH'(2): stateNext = TAKE2;
            CTRL_WIDTH'(3): stateNext = TAKE1_THEN2;
            default:        badSet    = 1'b1;
          endcase
        end
      end
      TAKE1:       if (d1Fire) stateNext = IDLE;
      TAKE2:       if (d2Fire) stateNext = IDLE;
      TAKE1_THEN2: if (d1Fire) stateNext = TAKE2;
      default:     stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      running <= 1'b0;
      badReg  <= 1'b0;
    end else begin
      state   <= stateNext;
      running <= 1'b1;
      if (badSet) badReg <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      count  <= '0;
      pktCnt <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop) begin
        rdPtr <= rdPtr + PTR_W'(1);
        if (pktCnt != '1) pktCnt <= pktCnt + CNT_WIDTH'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= pushData;
  end

endmodule

// File: tb/tb_merge_output_stage.sv
module tb_merge_output_stage;
  localparam int WIDTH      = 11;
  localparam int CTRL_WIDTH = 2;
  localparam int DEPTH      = 4;
  localparam int CNT_WIDTH  = 16;

  logic clk = 1'b0;
  logic reset;
  logic [WIDTH-1:0] d1_data, d2_data, out_data;
  logic d1_valid, d1_ready, d2_valid, d2_ready;
  logic [CTRL_WIDTH-1:0] ctrl_data;
  logic ctrl_valid, ctrl_ready, out_valid, out_ready;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [CNT_WIDTH-1:0] pkt_count;
  logic bad_ctrl;

  merge_output_stage #(
    .WIDTH(WIDTH), .CTRL_WIDTH(CTRL_WIDTH), .DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .reset(reset),
    .d1_data(d1_data), .d1_valid(d1_valid), .d1_ready(d1_ready),
    .d2_data(d2_data), .d2_valid(d2_valid), .d2_ready(d2_ready),
    .ctrl_data(ctrl_data), .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_count(fifo_count), .pkt_count(pkt_count), .bad_ctrl(bad_ctrl)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: outstanding packet demands (1 = d1, 2 = d2) and the
  // queue of packets waiting at the output.
  int dq[$];
  logic [WIDTH-1:0] oq[$];
  int unsigned pktM;
  bit badM, aliveM;

  logic [WIDTH-1:0] got[$];
  bit lastHC, lastH1, lastH2, lastHO;

  typedef struct {
    logic [CTRL_WIDTH-1:0] tok;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    int n;
    logic [WIDTH-1:0] e0;
    logic [WIDTH-1:0] e1;
    bit expBad;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    dq.delete();
    oq.delete();
    pktM   = 0;
    badM   = 1'b0;
    aliveM = 1'b0;
  endtask

  task automatic checkAll();
    logic [WIDTH-1:0] expData;
    bit e1, e2;
    expData = (oq.size() > 0) ? oq[0] : '0;
    e1 = (dq.size() > 0) && (dq[0] == 1) && (oq.size() < DEPTH);
    e2 = (dq.size() > 0) && (dq[0] == 2) && (oq.size() < DEPTH);
    chk("ctrl_ready", 32'(ctrl_ready), 32'(aliveM && (dq.size() == 0)));
    chk("d1_ready",   32'(d1_ready),   32'(e1));
    chk("d2_ready",   32'(d2_ready),   32'(e2));
    chk("out_valid",  32'(out_valid),  32'(oq.size() > 0));
    chk("fifo_count", 32'(fifo_count), 32'(oq.size()));
    chk("out_data",   32'(out_data),   32'(expData));
    chk("pkt_count",  32'(pkt_count),  32'(pktM));
    chk("bad_ctrl",   32'(bad_ctrl),   32'(badM));
  endtask

  // One clock: sample handshakes before the edge, advance the model, check.
  task automatic cycle();
    logic [CTRL_WIDTH-1:0] tok;
    logic [WIDTH-1:0] v1, v2, vo;
    #1;
    lastHC = ctrl_valid && ctrl_ready;
    lastH1 = d1_valid && d1_ready;
    lastH2 = d2_valid && d2_ready;
    lastHO = out_valid && out_ready;
    tok = ctrl_data;
    v1  = d1_data;
    v2  = d2_data;
    vo  = out_data;
    @(posedge clk);
    #1;
    if (reset) begin
      modelReset();
    end else begin
      if (lastHO && oq.size() > 0) begin
        got.push_back(vo);
        void'(oq.pop_front());
        if (pktM < (2**CNT_WIDTH) - 1) pktM++;
      end
      if (lastH1) begin
        if (dq.size() > 0) void'(dq.pop_front());
        oq.push_back(v1);
      end else if (lastH2) begin
        if (dq.size() > 0) void'(dq.pop_front());
        oq.push_back(v2);
      end
      if (lastHC) begin
        case (tok)
          2'd1: dq.push_back(1);
          2'd2: dq.push_back(2);
          2'd3: begin dq.push_back(1); dq.push_back(2); end
          default: badM = 1'b1;
        endcase
      end
      aliveM = 1'b1;
    end
    checkAll();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic sendTok(input logic [CTRL_WIDTH-1:0] t);
    int i;
    ctrl_valid = 1'b1;
    ctrl_data  = t;
    i = 0;
    lastHC = 1'b0;
    while (!lastHC && i < 20) begin cycle(); i++; end
    chk("tok_accept", 32'(lastHC), 32'd1);
    ctrl_valid = 1'b0;
  endtask

  task automatic sendD1(input logic [WIDTH-1:0] v);
    int i;
    d1_valid = 1'b1;
    d1_data  = v;
    i = 0;
    lastH1 = 1'b0;
    while (!lastH1 && i < 20) begin cycle(); i++; end
    chk("d1_accept", 32'(lastH1), 32'd1);
    d1_valid = 1'b0;
  endtask

  task automatic sendD2(input logic [WIDTH-1:0] v);
    int i;
    d2_valid = 1'b1;
    d2_data  = v;
    i = 0;
    lastH2 = 1'b0;
    while (!lastH2 && i < 20) begin cycle(); i++; end
    chk("d2_accept", 32'(lastH2), 32'd1);
    d2_valid = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{tok: 2'd1, d1: 11'h155, d2: 11'h0AA, n: 1, e0: 11'h155, e1: 11'h000, expBad: 1'b0};
    vecs[1] = '{tok: 2'd2, d1: 11'h3FF, d2: 11'h400, n: 1, e0: 11'h400, e1: 11'h000, expBad: 1'b0};
    vecs[2] = '{tok: 2'd3, d1: 11'h000, d2: 11'h7FF, n: 2, e0: 11'h000, e1: 11'h7FF, expBad: 1'b0};
    vecs[3] = '{tok: 2'd3, d1: 11'h5A5, d2: 11'h2DB, n: 2, e0: 11'h5A5, e1: 11'h2DB, expBad: 1'b0};
    vecs[4] = '{tok: 2'd0, d1: 11'h111, d2: 11'h222, n: 0, e0: 11'h000, e1: 11'h000, expBad: 1'b1};
    vecs[5] = '{tok: 2'd2, d1: 11'h0F0, d2: 11'h70F, n: 1, e0: 11'h70F, e1: 11'h000, expBad: 1'b1};

    reset = 1'b1;
    d1_data = '0; d1_valid = 1'b0;
    d2_data = '0; d2_valid = 1'b0;
    ctrl_data = '0; ctrl_valid = 1'b0;
    out_ready = 1'b0;
    modelReset();
    @(posedge clk);
    #1;
    checkAll();
    reset = 1'b0;
    cycle();
    chk("first_edge_ctrl_ready", 32'(ctrl_ready), 32'd1);

    // Token 1 then one d1 packet
    sendTok(2'd1);
    chk("s1_d1_ready", 32'(d1_ready), 32'd1);
    sendD1(11'h2A5);
    chk("s1_out_valid", 32'(out_valid), 32'd1);
    chk("s1_out_data", 32'(out_data), 32'h2A5);
    got.delete();
    out_ready = 1'b1;
    cycle();
    chk("s1_pkt_count", 32'(pkt_count), 32'd1);
    chk("s1_got_n", 32'(got.size()), 32'd1);
    if (got.size() > 0) chk("s1_got0", 32'(got[0]), 32'h2A5);

    // Token 3 with d2 presented before d1
    out_ready = 1'b0;
    got.delete();
    d2_valid = 1'b1;
    d2_data  = 11'h7FF;
    sendTok(2'd3);
    run(2);
    chk("s2_d2_blocked", 32'(lastH2), 32'd0);
    chk("s2_d2_ready", 32'(d2_ready), 32'd0);
    sendD1(11'h001);
    sendD2(11'h7FF);
    out_ready = 1'b1;
    run(4);
    chk("s2_got_n", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      chk("s2_got0", 32'(got[0]), 32'h001);
      chk("s2_got1", 32'(got[1]), 32'h7FF);
    end

    // Fill the FIFO with d2 packets while the consumer stalls
    out_ready = 1'b0;
    got.delete();
    for (int i = 0; i < 4; i++) begin
      sendTok(2'd2);
      sendD2(WIDTH'(10 + i));
    end
    chk("s3_full_count", 32'(fifo_count), 32'd4);
    sendTok(2'd2);
    d2_valid = 1'b1;
    d2_data  = WIDTH'(14);
    run(3);
    chk("s3_d2_ready_full", 32'(d2_ready), 32'd0);
    chk("s3_no_push", 32'(lastH2), 32'd0);
    chk("s3_count_held", 32'(fifo_count), 32'd4);
    out_ready = 1'b1;
    begin
      int i;
      i = 0;
      lastH2 = 1'b0;
      while (!lastH2 && i < 20) begin cycle(); i++; end
      chk("s3_fifth_accept", 32'(lastH2), 32'd1);
    end
    d2_valid = 1'b0;
    run(6);
    chk("s3_got_n", 32'(got.size()), 32'd5);
    if (got.size() == 5)
      for (int i = 0; i < 5; i++) chk("s3_order", 32'(got[i]), 32'(10 + i));

    // Illegal token is dropped and flagged
    got.delete();
    sendTok(2'd0);
    chk("s4_bad", 32'(bad_ctrl), 32'd1);
    chk("s4_no_push", 32'(fifo_count), 32'd0);
    chk("s4_idle", 32'(ctrl_ready), 32'd1);
    run(2);
    chk("s4_bad_sticky", 32'(bad_ctrl), 32'd1);
    sendTok(2'd1);
    sendD1(11'h123);
    run(3);
    chk("s4_got_n", 32'(got.size()), 32'd1);
    if (got.size() > 0) chk("s4_got0", 32'(got[0]), 32'h123);

    // Full FIFO: pop and d1 offered in the same cycle -> pop only
    out_ready = 1'b0;
    got.delete();
    for (int i = 0; i < 4; i++) begin
      sendTok(2'd1);
      sendD1(WIDTH'(11'h100 + i));
    end
    sendTok(2'd1);
    chk("s5_full", 32'(fifo_count), 32'd4);
    chk("s5_d1_ready", 32'(d1_ready), 32'd0);
    d1_valid  = 1'b1;
    d1_data   = 11'h1FF;
    out_ready = 1'b1;
    cycle();
    chk("s5_pop", 32'(lastHO), 32'd1);
    chk("s5_push_refused", 32'(lastH1), 32'd0);
    chk("s5_count3", 32'(fifo_count), 32'd3);
    out_ready = 1'b0;
    cycle();
    chk("s5_push_next", 32'(lastH1), 32'd1);
    chk("s5_count4", 32'(fifo_count), 32'd4);
    d1_valid  = 1'b0;
    out_ready = 1'b1;
    run(8);
    chk("s5_got_n", 32'(got.size()), 32'd5);
    if (got.size() == 5) begin
      chk("s5_got0", 32'(got[0]), 32'h100);
      chk("s5_got3", 32'(got[3]), 32'h103);
      chk("s5_got4", 32'(got[4]), 32'h1FF);
    end

    // Asynchronous reset while waiting in TAKE1_THEN2 with 2 entries queued
    out_ready = 1'b0;
    sendTok(2'd1);
    sendD1(11'h011);
    sendTok(2'd1);
    sendD1(11'h022);
    sendTok(2'd3);
    chk("s6_queued", 32'(fifo_count), 32'd2);
    chk("s6_take1", 32'(d1_ready), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("s6_async_valid", 32'(out_valid), 32'd0);
    chk("s6_async_count", 32'(fifo_count), 32'd0);
    chk("s6_async_data", 32'(out_data), 32'd0);
    chk("s6_async_ctrl_ready", 32'(ctrl_ready), 32'd0);
    chk("s6_async_d1_ready", 32'(d1_ready), 32'd0);
    modelReset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("s6_released_ctrl_ready", 32'(ctrl_ready), 32'd0);
    cycle();
    chk("s6_after_edge_ctrl_ready", 32'(ctrl_ready), 32'd1);
    chk("s6_after_edge_d1_ready", 32'(d1_ready), 32'd0);

    // Table of single-token transactions
    out_ready = 1'b1;
    foreach (vecs[k]) begin
      got.delete();
      d1_valid = 1'b1; d1_data = vecs[k].d1;
      d2_valid = 1'b1; d2_data = vecs[k].d2;
      sendTok(vecs[k].tok);
      run(6);
      d1_valid = 1'b0;
      d2_valid = 1'b0;
      run(2);
      chk("tbl_n", 32'(got.size()), 32'(vecs[k].n));
      if (vecs[k].n > 0 && got.size() > 0) chk("tbl_e0", 32'(got[0]), 32'(vecs[k].e0));
      if (vecs[k].n > 1 && got.size() > 1) chk("tbl_e1", 32'(got[1]), 32'(vecs[k].e1));
      chk("tbl_bad", 32'(bad_ctrl), 32'(vecs[k].expBad));
    end

    // Randomized traffic against the model
    lastHC = 1'b0; lastH1 = 1'b0; lastH2 = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!ctrl_valid || lastHC) begin
        ctrl_valid = ($urandom_range(0, 2) == 0);
        ctrl_data  = ($urandom_range(0, 15) == 0) ? 2'd0 : CTRL_WIDTH'($urandom_range(1, 3));
      end
      if (!d1_valid || lastH1) begin
        d1_valid = 1'($urandom_range(0, 1));
        d1_data  = WIDTH'($urandom);
      end
      if (!d2_valid || lastH2) begin
        d2_valid = 1'($urandom_range(0, 1));
        d2_data  = WIDTH'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    ctrl_valid = 1'b0;
    d1_valid   = 1'b0;
    d2_valid   = 1'b0;
    out_ready  = 1'b1;
    run(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
